// File: rtl/driver_cntrl_pkg.sv
// Shared register map, CTRL/STATUS bit positions and program-state encoding
// for driver_cntrl_mc and drv_addr_burst_gen.
package driver_cntrl_pkg;

  localparam logic [31:0] REG_ADDR_FIFO  = 32'h0000_0000;
  localparam logic [31:0] REG_CTRL       = 32'h0000_0004;
  localparam logic [31:0] REG_STRIDE     = 32'h0000_0008;
  localparam logic [31:0] REG_STATUS     = 32'h0000_0100;
  localparam logic [31:0] REG_ADDR_CYC   = 32'h0000_0104;
  localparam logic [31:0] REG_ADDR_WORDS = 32'h0000_0108;
  localparam logic [31:0] REG_VCTR_CYC   = 32'h0000_010C;
  localparam logic [31:0] REG_VCTR_WORDS = 32'h0000_0110;
  localparam logic [31:0] REG_IRQ_STAT   = 32'h0000_0114;
  localparam logic [31:0] REG_IRQ_MASK   = 32'h0000_0118;

  localparam logic [19:0] ADDR_MON_PAGE = 20'h00011;
  localparam logic [19:0] VCTR_MON_PAGE = 20'h00012;

  localparam int CTRL_RUN         = 0;
  localparam int CTRL_END         = 1;
  localparam int CTRL_ABORT       = 2;
  localparam int CTRL_FRZ_ADDR    = 3;
  localparam int CTRL_FRZ_VCTR    = 4;
  localparam int CTRL_FREEZE_PROG = 6;
  localparam int CTRL_SEND_CONSEC = 7;
  localparam int CTRL_CONSEC_LSB  = 8;

  localparam int ST_BUSY     = 3;
  localparam int ST_OVERFLOW = 4;
  localparam int ST_DONE     = 5;
  localparam int ST_ABORTED  = 6;

  localparam int IRQ_DONE     = 0;
  localparam int IRQ_ABORTED  = 1;
  localparam int IRQ_OVERFLOW = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_FROZEN  = 3'd2,
    S_DONE    = 3'd3,
    S_ABORTED = 3'd4
  } prog_state_t;

endpackage

// File: rtl/drv_addr_burst_gen.sv
// Consecutive-address burst generator: loads base/stride/count, pushes one
// word per cycle while the FIFO has room, cancellable.
module drv_addr_burst_gen
  import driver_cntrl_pkg::*;
#(
  parameter int CONSEC_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                cancel,
  input  logic                fifo_full,
  input  logic [31:0]         base,
  input  logic [31:0]         stride,
  input  logic [CONSEC_W-1:0] count,
  output logic [31:0]         word,
  output logic [31:0]         last_word,
  output logic                push,
  output logic                busy
);

  logic [CONSEC_W-1:0] rem;

  assign push = (rem != '0) && !fifo_full;
  // busy means words will still be owed after this edge
  assign busy = (rem != '0) && !((rem == CONSEC_W'(1)) && push);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem       <= '0;
      word      <= '0;
      last_word <= '0;
    end else begin
      if (push) begin
        last_word <= word;
        word      <= word + stride;
      end
      if (cancel) begin
        rem <= '0;
      end else if (load) begin
        rem  <= (count == '0) ? CONSEC_W'(1) : count;
        word <= base;
      end else if (push) begin
        rem <= rem - CONSEC_W'(1);
      end
    end
  end

endmodule

// File: rtl/driver_cntrl_mc.sv
// Driver controller register file, program FSM and burst front-end.
// Optional DRV_CNTRL_IRQ_EN adds IRQ_STAT/IRQ_MASK and the irq port.
module driver_cntrl_mc
  import driver_cntrl_pkg::*;
#(
  parameter int ADDR_MON_BINS = 16,
  parameter int VCTR_MON_BINS = 16,
  parameter int MON_CNT_W     = 16,
  parameter int FIFO_CNT_W    = 16,
  parameter int CONSEC_W      = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [31:0]                        slave_addr,
  input  logic                               slave_rd,
  input  logic                               slave_wr,
  input  logic [31:0]                        slave_data_in,
  output logic [31:0]                        slave_data_out,
  input  logic [ADDR_MON_BINS*MON_CNT_W-1:0] addr_mon_cnts_flat,
  input  logic [VCTR_MON_BINS*MON_CNT_W-1:0] vctr_mon_cnts_flat,
  input  logic [FIFO_CNT_W-1:0]              addr_cycle_cnt,
  input  logic [FIFO_CNT_W-1:0]              vctr_cycle_cnt,
  input  logic [FIFO_CNT_W-1:0]              words_in_addr_fifo,
  input  logic [FIFO_CNT_W-1:0]              words_in_vctr_fifo,
  input  logic                               addr_fifo_full,
  output logic [31:0]                        addr_fifo_din,
  output logic                               addr_fifo_wr,
  output logic                               run_program,
  output logic                               end_program,
  output logic                               abort_program,
  output logic                               active_program,
  output logic                               freeze_addr_fifo,
`ifdef DRV_CNTRL_IRQ_EN
  output logic                               irq,
`endif
  output logic                               freeze_vctr_fifo
);

  localparam logic [31:0] CTRL_KEEP =
    ((32'(1) << (CONSEC_W + 8)) - 32'd256) | 32'h0000_00D8;

  prog_state_t state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d, stride_q, rd_val;
  logic [31:0] addr_bin, vctr_bin, last_word;
  logic [2:0]  cmd;
  logic [9:0]  bin_idx;
  logic        wr_fifo, wr_ctrl, wr_stride, wr_status;
  logic        go_run, go_end, go_abort, busy, load, drop;
  logic        overflow_q, done_q, aborted_q;
  logic        addr_bin_hit, vctr_bin_hit;
  logic [CONSEC_W-1:0] burst_len;

  assign wr_fifo   = slave_wr && (slave_addr == REG_ADDR_FIFO);
  assign wr_ctrl   = slave_wr && (slave_addr == REG_CTRL);
  assign wr_stride = slave_wr && (slave_addr == REG_STRIDE);
  assign wr_status = slave_wr && (slave_addr == REG_STATUS);

  assign cmd    = wr_ctrl ? slave_data_in[2:0] : 3'b000;
  assign ctrl_d = wr_ctrl ? (slave_data_in & CTRL_KEEP) : ctrl_q;
  assign load   = wr_fifo && !busy;
  assign drop   = wr_fifo && busy;

  assign burst_len = ctrl_q[CTRL_SEND_CONSEC] ?
                     ctrl_q[CTRL_CONSEC_LSB +: CONSEC_W] : CONSEC_W'(1);

  drv_addr_burst_gen #(.CONSEC_W(CONSEC_W)) u_burst (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .cancel    (go_abort),
    .fifo_full (addr_fifo_full),
    .base      (slave_data_in),
    .stride    (stride_q),
    .count     (burst_len),
    .word      (addr_fifo_din),
    .last_word (last_word),
    .push      (addr_fifo_wr),
    .busy      (busy)
  );

  // abort > end > run; freeze follows the CTRL bit while a program is live
  always_comb begin
    state_d  = state_q;
    go_run   = 1'b0;
    go_end   = 1'b0;
    go_abort = 1'b0;
    unique case (state_q)
      S_RUN, S_FROZEN: begin
        if (cmd[CTRL_ABORT]) begin
          state_d  = S_ABORTED;
          go_abort = 1'b1;
        end else if (cmd[CTRL_END]) begin
          state_d = S_DONE;
          go_end  = 1'b1;
        end else begin
          state_d = ctrl_d[CTRL_FREEZE_PROG] ? S_FROZEN : S_RUN;
        end
      end
      default: begin
        if (cmd[CTRL_RUN]) begin
          state_d = S_RUN;
          go_run  = 1'b1;
        end
      end
    endcase
  end

  assign bin_idx      = slave_addr[11:2];
  assign addr_bin_hit = (slave_addr[31:12] == ADDR_MON_PAGE) &&
                        (slave_addr[1:0] == 2'b00);
  assign vctr_bin_hit = (slave_addr[31:12] == VCTR_MON_PAGE) &&
                        (slave_addr[1:0] == 2'b00);

  always_comb begin
    addr_bin = '0;
    for (int i = 0; i < ADDR_MON_BINS; i++)
      if (bin_idx == 10'(i))
        addr_bin = 32'(addr_mon_cnts_flat[i*MON_CNT_W +: MON_CNT_W]);
  end

  always_comb begin
    vctr_bin = '0;
    for (int i = 0; i < VCTR_MON_BINS; i++)
      if (bin_idx == 10'(i))
        vctr_bin = 32'(vctr_mon_cnts_flat[i*MON_CNT_W +: MON_CNT_W]);
  end

`ifdef DRV_CNTRL_IRQ_EN
  logic [2:0] irq_stat_q, irq_mask_q;
  logic       wr_istat, wr_imask;

  assign wr_istat = slave_wr && (slave_addr == REG_IRQ_STAT);
  assign wr_imask = slave_wr && (slave_addr == REG_IRQ_MASK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~(wr_istat ? slave_data_in[2:0] : 3'b000))
                  | {drop, go_abort, go_end};
      if (wr_imask) irq_mask_q <= slave_data_in[2:0];
      irq <= |(irq_stat_q & irq_mask_q);
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      addr_bin_hit: rd_val = addr_bin;
      vctr_bin_hit: rd_val = vctr_bin;
      default: begin
        case (slave_addr)
          REG_ADDR_FIFO:  rd_val = last_word;
          REG_CTRL:       rd_val = ctrl_q;
          REG_STRIDE:     rd_val = stride_q;
          REG_STATUS:     rd_val = {25'd0, aborted_q, done_q, overflow_q,
                                    busy, state_q};
          REG_ADDR_CYC:   rd_val = 32'(addr_cycle_cnt);
          REG_ADDR_WORDS: rd_val = 32'(words_in_addr_fifo);
          REG_VCTR_CYC:   rd_val = 32'(vctr_cycle_cnt);
          REG_VCTR_WORDS: rd_val = 32'(words_in_vctr_fifo);
`ifdef DRV_CNTRL_IRQ_EN
          REG_IRQ_STAT:   rd_val = {29'd0, irq_stat_q};
          REG_IRQ_MASK:   rd_val = {29'd0, irq_mask_q};
`endif
          default:        rd_val = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      ctrl_q           <= '0;
      stride_q         <= 32'd4;
      overflow_q       <= 1'b0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
      run_program      <= 1'b0;
      end_program      <= 1'b0;
      abort_program    <= 1'b0;
      active_program   <= 1'b0;
      freeze_addr_fifo <= 1'b0;
      freeze_vctr_fifo <= 1'b0;
      slave_data_out   <= '0;
    end else begin
      state_q          <= state_d;
      ctrl_q           <= ctrl_d;
      if (wr_stride) stride_q <= slave_data_in;
      overflow_q <= (overflow_q & !(wr_status && slave_data_in[ST_OVERFLOW]))
                  | drop;
      done_q     <= (done_q & !(wr_status && slave_data_in[ST_DONE]))
                  | go_end;
      aborted_q  <= (aborted_q & !(wr_status && slave_data_in[ST_ABORTED]))
                  | go_abort;
      run_program      <= go_run;
      end_program      <= go_end;
      abort_program    <= go_abort;
      active_program   <= (state_d == S_RUN) || (state_d == S_FROZEN);
      freeze_addr_fifo <= ctrl_d[CTRL_FRZ_ADDR] || (state_d == S_FROZEN);
      freeze_vctr_fifo <= ctrl_d[CTRL_FRZ_VCTR] || (state_d == S_FROZEN);
      if (slave_rd) slave_data_out <= rd_val;
    end
  end

endmodule

// File: tb/tb_driver_cntrl_mc.sv
// Directed bench for driver_cntrl_mc with a transaction-level model of
// the register file, program state and expected FIFO push stream.
`timescale 1ns/1ps
module tb_driver_cntrl_mc;

  localparam int AB = 16;
  localparam int VB = 16;
  localparam int MW = 16;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   slave_addr, slave_data_in, slave_data_out;
  logic          slave_rd, slave_wr;
  logic [AB*MW-1:0] addr_mon_cnts_flat;
  logic [VB*MW-1:0] vctr_mon_cnts_flat;
  logic [FW-1:0] addr_cycle_cnt, vctr_cycle_cnt;
  logic [FW-1:0] words_in_addr_fifo, words_in_vctr_fifo;
  logic          addr_fifo_full;
  logic [31:0]   addr_fifo_din;
  logic          addr_fifo_wr;
  logic          run_program, end_program, abort_program;
  logic          active_program, freeze_addr_fifo, freeze_vctr_fifo;
`ifdef DRV_CNTRL_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  driver_cntrl_mc #(
    .ADDR_MON_BINS(AB), .VCTR_MON_BINS(VB), .MON_CNT_W(MW),
    .FIFO_CNT_W(FW), .CONSEC_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .slave_addr(slave_addr), .slave_rd(slave_rd), .slave_wr(slave_wr),
    .slave_data_in(slave_data_in), .slave_data_out(slave_data_out),
    .addr_mon_cnts_flat(addr_mon_cnts_flat),
    .vctr_mon_cnts_flat(vctr_mon_cnts_flat),
    .addr_cycle_cnt(addr_cycle_cnt), .vctr_cycle_cnt(vctr_cycle_cnt),
    .words_in_addr_fifo(words_in_addr_fifo),
    .words_in_vctr_fifo(words_in_vctr_fifo),
    .addr_fifo_full(addr_fifo_full), .addr_fifo_din(addr_fifo_din),
    .addr_fifo_wr(addr_fifo_wr),
    .run_program(run_program), .end_program(end_program),
    .abort_program(abort_program), .active_program(active_program),
    .freeze_addr_fifo(freeze_addr_fifo),
`ifdef DRV_CNTRL_IRQ_EN
    .irq(irq),
`endif
    .freeze_vctr_fifo(freeze_vctr_fifo)
  );

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 frozen, 3 done, 4 aborted
  int          st;
  logic [31:0] ctrl_m, stride_m, last_m;
  logic        ovf_m, done_m, abt_m, p_run, p_end, p_abort;
  logic [2:0]  istat_m, imask_m;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] reg_model(input logic [31:0] a);
    case (a)
      32'h000: return last_m;
      32'h004: return ctrl_m;
      32'h008: return stride_m;
      32'h100: return {25'd0, abt_m, done_m, ovf_m, exp_q.size() != 0, 3'(st)};
      32'h104: return 32'(addr_cycle_cnt);
      32'h108: return 32'(words_in_addr_fifo);
      32'h10C: return 32'(vctr_cycle_cnt);
      32'h110: return 32'(words_in_vctr_fifo);
`ifdef DRV_CNTRL_IRQ_EN
      32'h114: return {29'd0, istat_m};
      32'h118: return {29'd0, imask_m};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    st = 0; ctrl_m = 0; stride_m = 4; last_m = 0;
    ovf_m = 0; done_m = 0; abt_m = 0;
    p_run = 0; p_end = 0; p_abort = 0;
    istat_m = 0; imask_m = 0;
    exp_q.delete();
  endtask

  task automatic compare_cycle();
    logic [5:0] act_o, exp_o;
    act_o = {active_program, freeze_addr_fifo, freeze_vctr_fifo,
             run_program, end_program, abort_program};
    exp_o = {st == 1 || st == 2, ctrl_m[3] || st == 2, ctrl_m[4] || st == 2,
             p_run, p_end, p_abort};
    check("ctrl_outs", 32'(act_o), 32'(exp_o));
    p_run = 0; p_end = 0; p_abort = 0;
    if (addr_fifo_wr) begin
      log_q.push_back(addr_fifo_din);
      if (addr_fifo_full) check("wr_while_full", 32'(addr_fifo_full), 32'h0);
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_push: got 0x%08h, want no push", addr_fifo_din);
      end else begin
        last_m = exp_q.pop_front();
        check("push_word", addr_fifo_din, last_m);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (reset) compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    case (a)
      32'h000: begin
        if (exp_q.size() != 0) begin
          ovf_m = 1; istat_m[2] = 1;
        end else begin
          n = ctrl_m[7] ? int'(ctrl_m[15:8]) : 1;
          if (n == 0) n = 1;
          for (int i = 0; i < n; i++) exp_q.push_back(d + stride_m * 32'(i));
        end
      end
      32'h004: begin
        ctrl_m = d & 32'h0000_FFD8;
        if (st == 1 || st == 2) begin
          if (d[2]) begin
            st = 4; p_abort = 1; abt_m = 1; istat_m[1] = 1; exp_q.delete();
          end else if (d[1]) begin
            st = 3; p_end = 1; done_m = 1; istat_m[0] = 1;
          end else st = d[6] ? 2 : 1;
        end else if (d[0]) begin
          st = 1; p_run = 1;
        end
      end
      32'h008: stride_m = d;
      32'h100: begin
        if (d[4]) ovf_m = 0;
        if (d[5]) done_m = 0;
        if (d[6]) abt_m = 0;
      end
`ifdef DRV_CNTRL_IRQ_EN
      32'h114: istat_m = istat_m & ~d[2:0];
      32'h118: imask_m = d[2:0];
`endif
      default: ;
    endcase
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    slave_addr = a; slave_data_in = d; slave_wr = 1;
    step();
    slave_wr = 0;
    model_write(a, d);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    slave_addr = a; slave_rd = 1;
    step();
    slave_rd = 0;
    d = slave_data_out;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic rd_model(input string name, input logic [31:0] a);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, d, reg_model(a));
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    step(); step();
    reset = 1;
  endtask

  initial begin
    slave_addr = 0; slave_data_in = 0; slave_rd = 0; slave_wr = 0;
    addr_fifo_full = 0;
    addr_cycle_cnt = 16'h1111; words_in_addr_fifo = 16'h2222;
    vctr_cycle_cnt = 16'h3333; words_in_vctr_fifo = 16'h4444;
    for (int i = 0; i < AB; i++) addr_mon_cnts_flat[i*MW +: MW] = 16'hA000 + 16'(i);
    for (int i = 0; i < VB; i++) vctr_mon_cnts_flat[i*MW +: MW] = 16'hB000 + 16'(i);
    @(posedge clk); #1;
    do_reset();

    check("rst_outs", 32'({addr_fifo_wr, run_program, end_program, abort_program,
          active_program, freeze_addr_fifo, freeze_vctr_fifo}), 32'h0);
    check("rst_din", addr_fifo_din, 32'h0);
    rd_chk("rst_status", 32'h100, 32'h0);
    rd_chk("rst_stride", 32'h008, 32'h4);
    rd_chk("rst_ctrl", 32'h004, 32'h0);

    // single push
    log_q.delete();
    bus_wr(32'h000, 32'h1234);
    rd_chk("single_status", 32'h100, 32'h0);
    repeat (2) step();
    check("single_n", 32'(log_q.size()), 1);
    check("single_w0", log_at(0), 32'h1234);
    rd_chk("last_word", 32'h000, 32'h1234);

    // 4-word burst, full during cycles 2-3
    bus_wr(32'h008, 32'h4);
    bus_wr(32'h004, 32'h0480);
    rd_model("ctrl_rb", 32'h004);
    log_q.delete();
    bus_wr(32'h000, 32'h100);
    step();
    addr_fifo_full = 1;
    step(); step();
    check("stall_n", 32'(log_q.size()), 1);
    addr_fifo_full = 0;
    repeat (6) step();
    check("burst_n", 32'(log_q.size()), 4);
    check("burst_w0", log_at(0), 32'h100);
    check("burst_w1", log_at(1), 32'h104);
    check("burst_w2", log_at(2), 32'h108);
    check("burst_w3", log_at(3), 32'h10C);

    // wrap + dropped second base
    bus_wr(32'h004, 32'h0380);
    log_q.delete();
    bus_wr(32'h000, 32'hFFFF_FFFC);
    bus_wr(32'h000, 32'h5000);
    rd_chk("ovf_status", 32'h100, 32'h18);
    repeat (4) step();
    check("wrap_n", 32'(log_q.size()), 3);
    check("wrap_w0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_w1", log_at(1), 32'h0);
    check("wrap_w2", log_at(2), 32'h4);
    rd_chk("ovf_sticky", 32'h100, 32'h10);
    bus_wr(32'h100, 32'h10);
    rd_model("ovf_w1c", 32'h100);

    // program FSM
    bus_wr(32'h004, 32'h1);
    check("run_pulse", 32'({run_program, active_program}), 32'h3);
    rd_chk("run_status", 32'h100, 32'h1);
    bus_wr(32'h004, 32'h40);
    check("frozen_outs", 32'({active_program, freeze_addr_fifo, freeze_vctr_fifo}), 32'h7);
    rd_chk("frz_status", 32'h100, 32'h2);
    bus_wr(32'h004, 32'h08C0);
    log_q.delete();
    bus_wr(32'h000, 32'h2000);
    bus_wr(32'h004, 32'h6);
    check("abort_pulse", 32'({abort_program, end_program, active_program}), 32'h4);
    repeat (4) step();
    check("abort_cancel_n", 32'(log_q.size()), 1);
    rd_chk("abort_status", 32'h100, 32'h44);
    bus_wr(32'h004, 32'h1);
    bus_wr(32'h004, 32'h1);
    check("run_ignored", 32'(run_program), 32'h0);
    bus_wr(32'h004, 32'h2);
    rd_chk("done_status", 32'h100, 32'h63);
    bus_wr(32'h004, 32'h18);
    check("fifo_frz", 32'({active_program, freeze_addr_fifo, freeze_vctr_fifo}), 32'h3);
    bus_wr(32'h100, 32'h70);
    rd_model("st_clr", 32'h100);
    bus_wr(32'h004, 32'h0);

    // monitor and counter readback
    rd_chk("abin_last", 32'h0001_1000 + 32'(4 * (AB - 1)), 32'h0000_A00F);
    rd_chk("abin_oor", 32'h0001_1000 + 32'(4 * AB), 32'h0);
    rd_chk("abin0", 32'h0001_1000, 32'h0000_A000);
    rd_chk("vbin3", 32'h0001_200C, 32'h0000_B003);
    rd_model("addr_cyc", 32'h104);
    rd_model("addr_words", 32'h108);
    rd_chk("vctr_cyc", 32'h10C, 32'h3333);
    rd_model("vctr_words", 32'h110);
    rd_chk("unmapped", 32'h00C, 32'h0);

`ifdef DRV_CNTRL_IRQ_EN
    rd_model("irq_stat_pre", 32'h114);
    bus_wr(32'h114, 32'h7);
    bus_wr(32'h118, 32'h1);
    rd_model("irq_mask", 32'h118);
    bus_wr(32'h004, 32'h1);
    bus_wr(32'h004, 32'h2);
    step(); step();
    check("irq_set", 32'(irq), 32'h1);
    bus_wr(32'h114, 32'h1);
    step(); step();
    check("irq_clr", 32'(irq), 32'h0);
    rd_model("irq_stat_post", 32'h114);
`else
    bus_wr(32'h118, 32'h1);
    rd_chk("irq_mask_absent", 32'h118, 32'h0);
    rd_chk("irq_stat_absent", 32'h114, 32'h0);
`endif

    // reset while a burst is stalled
    bus_wr(32'h004, 32'h0580);
    bus_wr(32'h008, 32'h10);
    addr_fifo_full = 1;
    bus_wr(32'h000, 32'h3000);
    step();
    do_reset();
    addr_fifo_full = 0;
    repeat (4) step();
    check("rst2_outs", 32'({addr_fifo_wr, active_program, freeze_addr_fifo}), 32'h0);
    rd_chk("rst2_stride", 32'h008, 32'h4);
    rd_chk("rst2_ctrl", 32'h004, 32'h0);
    rd_chk("rst2_last", 32'h000, 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
